lsu_mem_ctrl: RTL and testbench

- Load/store unit sitting directly downstream of the instruction decoder/control block in the RV32I core.
- Consumes the decoded mem_read, mem_write and funct3 controls plus the ALU-computed effective address and rs2 store data.
- Runs a request/grant/response handshake to the data-memory port, with byte-lane alignment, load sign/zero extension, misalignment detection and a response watchdog.
- Stalls the pipeline via o_ready while a transaction is in flight.

---
 rtl/rv32i_lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 66 ++++++
 rtl/lsu_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM
// encoding, default watchdog depth and the access-size decode helper.
package rv32i_lsu_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    // Unused codes 011/110/111 fall through to a full word access.
    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        lsu_size_e sz;
        case (funct3[1:0])
            2'b00:   sz = SZ_B;
            2'b01:   sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store mask/data placement, load
// extraction with sign/zero extension, and the misalignment check.
module lsu_align
    import rv32i_lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    lsu_size_e   size;
    logic        sign_ext;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign size     = size_of(funct3);
    assign sign_ext = ~funct3[2];
    assign byte_val = 8'(rdata >> {offset, 3'b000});
    assign half_val = 16'(rdata >> {offset[1], 4'b0000});

    // Store side: replicate the datum across lanes and enable only its bytes.
    always_comb begin
        mask       = 4'b1111;
        lane_wdata = wdata;
        case (size)
            SZ_B: begin
                mask       = 4'b0001 << offset;
                lane_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                mask       = 4'b0011 << offset;
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                mask       = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
    end

    // Load side: pick the addressed byte/half and extend it to 32 bits.
    always_comb begin
        load_data = rdata;
        case (size)
            SZ_B:    load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
            SZ_H:    load_data = {{16{sign_ext & half_val[15]}}, half_val};
            default: load_data = rdata;
        endcase
    end

    // Halfwords need even addresses, words need 4-byte alignment.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_H:    misaligned = offset[0];
            SZ_W:    misaligned = |offset;
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one decoded memory op at a time, drives the
// req/gnt/rvalid data-memory handshake and reports completion with a
// one-cycle o_done pulse. A watchdog aborts accesses stuck in REQ+WAIT.
// TIMEOUT_CYCLES must be at least 2 and fit in CNT_W bits.
module lsu_mem_ctrl
    import rv32i_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_dmem_req,
    output logic        o_dmem_wen,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_mask,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic        o_misaligned,
    output logic        o_fault
);

    // Handshake: a request is taken on a cycle where i_valid && o_ready; the
    // bus request o_dmem_req stays high until a cycle with i_dmem_gnt, and
    // load data is taken on the first i_dmem_rvalid after that grant.

    lsu_state_e       state;
    lsu_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [2:0]       funct3_q;
    logic [31:0]      wdata_q;
    logic             is_load_q;
    logic             is_store_q;
    logic             misaligned_q;
    logic             fault_q;
    logic [31:0]      load_data_q;

    logic             accept;
    logic             op_load;
    logic             op_store;
    logic             expired;
    logic [1:0]       align_offset;
    logic [2:0]       align_funct3;
    logic [3:0]       align_mask;
    logic [31:0]      align_wdata;
    logic [31:0]      align_load;
    logic             align_misaligned;

    assign accept   = i_valid && (state == ST_IDLE);
    assign op_load  = i_mem_read;
    assign op_store = i_mem_write && !i_mem_read;
    assign expired  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // In IDLE the aligner looks at the incoming op for the misalignment
    // check; afterwards it works from the captured op.
    assign align_offset = (state == ST_IDLE) ? i_addr[1:0] : addr_q[1:0];
    assign align_funct3 = (state == ST_IDLE) ? i_funct3    : funct3_q;

    lsu_align u_align (
        .offset     (align_offset),
        .funct3     (align_funct3),
        .wdata      (wdata_q),
        .rdata      (i_dmem_rdata),
        .mask       (align_mask),
        .lane_wdata (align_wdata),
        .load_data  (align_load),
        .misaligned (align_misaligned)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; a completing gnt/rvalid beats the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!(op_load || op_store))  state_next = ST_DONE;
                    else if (align_misaligned)   state_next = ST_DONE;
                    else                         state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_dmem_gnt)   state_next = is_store_q ? ST_DONE : ST_WAIT;
                else if (expired) state_next = ST_DONE;
            end
            ST_WAIT: begin
                if (i_dmem_rvalid) state_next = ST_DONE;
                else if (expired)  state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are zero outside REQ.
    always_comb begin
        o_ready      = (state == ST_IDLE);
        o_done       = (state == ST_DONE);
        o_dmem_req   = 1'b0;
        o_dmem_wen   = 1'b0;
        o_dmem_addr  = 32'h0;
        o_dmem_wdata = 32'h0;
        o_dmem_mask  = 4'h0;
        if (state == ST_REQ) begin
            o_dmem_req   = 1'b1;
            o_dmem_wen   = is_store_q;
            o_dmem_addr  = {addr_q[31:2], 2'b00};
            o_dmem_wdata = align_wdata;
            o_dmem_mask  = align_mask;
        end
    end

    // Capture the op on accept so bus fields stay stable while in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q     <= 32'h0;
            funct3_q   <= 3'b000;
            wdata_q    <= 32'h0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
        end else if (accept) begin
            addr_q     <= i_addr;
            funct3_q   <= i_funct3;
            wdata_q    <= i_wdata;
            is_load_q  <= op_load;
            is_store_q <= op_store;
        end
    end

    // Watchdog: restarts on accept, counts every REQ/WAIT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt <= '0;
        else if (accept)
            cnt <= '0;
        else if (state == ST_REQ || state == ST_WAIT)
            cnt <= cnt + 1'b1;
    end

    // Result flags: cleared on accept, set only on the way into DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misaligned_q <= 1'b0;
            fault_q      <= 1'b0;
            load_data_q  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        misaligned_q <= align_misaligned && (op_load || op_store);
                        fault_q      <= 1'b0;
                        load_data_q  <= 32'h0;
                    end
                end
                ST_REQ: begin
                    if (!i_dmem_gnt && expired) fault_q <= 1'b1;
                end
                ST_WAIT: begin
                    if (i_dmem_rvalid)  load_data_q <= is_load_q ? align_load : 32'h0;
                    else if (expired)   fault_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_misaligned = misaligned_q;
    assign o_fault      = fault_q;
    assign o_load_data  = load_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a main instance with the default watchdog and a
// second instance with a 4-cycle watchdog for the timeout case. Inputs are
// driven on the falling edge, outputs sampled on the falling edge.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        valid4;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    logic        ready,  dreq,  dwen,  done,  mis,  fault;
    logic [31:0] daddr,  dwdata, ldata;
    logic [3:0]  dmask;
    logic        ready4, dreq4, dwen4, done4, mis4, fault4;
    logic [31:0] daddr4, dwdata4, ldata4;
    logic [3:0]  dmask4;

    int vectors;
    int miscompares;
    int cyc;

    logic [33:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [33:0] exp4_q[$];
    int          exp4_cyc_q[$];

    lsu_mem_ctrl u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata),
        .o_dmem_req(dreq), .o_dmem_wen(dwen), .o_dmem_addr(daddr),
        .o_dmem_wdata(dwdata), .o_dmem_mask(dmask),
        .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
        .o_done(done), .o_load_data(ldata), .o_misaligned(mis), .o_fault(fault)
    );

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid4), .o_ready(ready4),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata),
        .o_dmem_req(dreq4), .o_dmem_wen(dwen4), .o_dmem_addr(daddr4),
        .o_dmem_wdata(dwdata4), .o_dmem_mask(dmask4),
        .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
        .o_done(done4), .o_load_data(ldata4), .o_misaligned(mis4), .o_fault(fault4)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the main instance: every o_done pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [33:0] e;
                int          ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("load_data",  ldata,      e[31:0]);
                check("misaligned", 32'(mis),   32'(e[32]));
                check("fault",      32'(fault), 32'(e[33]));
                check("done_cycle", 32'(cyc),   32'(ec));
            end
        end
    end

    // Monitor for the short-watchdog instance.
    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (exp4_q.size() == 0) begin
                check("unexpected_done4", 32'(done4), 32'd0);
            end else begin
                logic [33:0] e;
                int          ec;
                e  = exp4_q.pop_front();
                ec = exp4_cyc_q.pop_front();
                check("t_load_data",  ldata4,      e[31:0]);
                check("t_misaligned", 32'(mis4),   32'(e[32]));
                check("t_fault",      32'(fault4), 32'(e[33]));
                check("t_done_cycle", 32'(cyc),    32'(ec));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Drive one op on the main instance. gd = idle REQ cycles before gnt,
    // rdl = idle WAIT cycles before rvalid.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gd, input int rdl, input logic [31:0] rdat,
                          input logic bus, input logic [31:0] exp_baddr,
                          input logic [3:0] exp_mask, input logic [31:0] exp_bwdata,
                          input logic [31:0] exp_data, input logic exp_mis);
        int c;
        int dc;
        wait_ready();
        c = cyc;
        valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        if (!bus)    dc = c + 1;
        else if (rd) dc = c + 3 + gd + rdl;
        else         dc = c + 2 + gd;
        exp_q.push_back({1'b0, exp_mis, exp_data});
        exp_cyc_q.push_back(dc);
        @(negedge clk);
        valid = 1'b0;
        addr  = 32'($urandom);
        wdata = 32'($urandom);
        if (!bus) begin
            check("no_bus_req", 32'(dreq), 32'd0);
            return;
        end
        check("bus_addr", daddr, exp_baddr);
        check("bus_wen", 32'(dwen), 32'(wr && !rd));
        if (wr && !rd) begin
            check("bus_mask", 32'(dmask), 32'(exp_mask));
            check("bus_wdata", dwdata, exp_bwdata);
        end
        for (int k = 0; k <= gd; k++) begin
            if (k > 0) @(negedge clk);
            check("req_held", 32'(dreq), 32'd1);
            check("ready_low_req", 32'(ready), 32'd0);
            gnt = (k == gd);
        end
        @(negedge clk);
        gnt = 1'b0;
        if (rd) begin
            for (int k = 0; k <= rdl; k++) begin
                if (k > 0) @(negedge clk);
                check("ready_low_wait", 32'(ready), 32'd0);
                rvalid = (k == rdl);
                rdata  = (k == rdl) ? rdat : 32'($urandom);
            end
            @(negedge clk);
            rvalid = 1'b0;
        end
    endtask

    initial begin
        int c;
        vectors = 0; miscompares = 0; cyc = 0;
        valid = 0; valid4 = 0; mem_read = 0; mem_write = 0; funct3 = 3'b000;
        addr = 0; wdata = 0; gnt = 0; rvalid = 0; rdata = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_req",   32'(dreq),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_ready4", 32'(ready4), 32'd1);
        rst_n = 1'b1;

        // sb to lane 3.
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0, 1'b1,
               32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 1'b0);
        // lb / lbu of lane 1.
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000, 1'b1,
               32'h0000_2000, 4'b0, 32'h0, 32'hFFFF_FF80, 1'b0);
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000, 1'b1,
               32'h0000_2000, 4'b0, 32'h0, 32'h0000_0080, 1'b0);
        // lhu upper half, then lh with slow gnt and slow rvalid.
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_1234, 1'b1,
               32'h0000_2000, 4'b0, 32'h0, 32'h0000_BEEF, 1'b0);
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 3, 2, 32'hBEEF_1234, 1'b1,
               32'h0000_2000, 4'b0, 32'h0, 32'hFFFF_BEEF, 1'b0);
        // Misaligned lw and sh: no bus request.
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 0, 0, 32'h0, 1'b0,
               32'h0, 4'b0, 32'h0, 32'h0, 1'b1);
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h1234, 0, 0, 32'h0, 1'b0,
               32'h0, 4'b0, 32'h0, 32'h0, 1'b1);
        // sw with one-cycle gnt delay, sh to upper half.
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678, 1, 0, 32'h0, 1'b1,
               32'h0000_5000, 4'b1111, 32'h1234_5678, 32'h0, 1'b0);
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_5002, 32'h0000_CAFE, 0, 0, 32'h0, 1'b1,
               32'h0000_5000, 4'b1100, 32'hCAFE_CAFE, 32'h0, 1'b0);
        // Op with neither read nor write.
        run_op(1'b0, 1'b0, 3'b010, 32'h0000_5555, 32'h0, 0, 0, 32'h0, 1'b0,
               32'h0, 4'b0, 32'h0, 32'h0, 1'b0);
        // funct3 111 behaves as lw; read+write together behaves as a load.
        run_op(1'b1, 1'b0, 3'b111, 32'h0000_6000, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b1,
               32'h0000_6000, 4'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b1, 1'b1, 3'b000, 32'h0000_7000, 32'hFFFF_FFFF, 0, 0, 32'h0000_007F, 1'b1,
               32'h0000_7000, 4'b0, 32'h0, 32'h0000_007F, 1'b0);

        // Reset while in WAIT: everything drops, no completion.
        wait_ready();
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_4000;
        @(negedge clk);
        valid = 1'b0; gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_ready", 32'(ready),  32'd1);
        check("rst_wait_req",   32'(dreq),   32'd0);
        check("rst_wait_done",  32'(done),   32'd0);
        check("rst_wait_addr",  daddr,       32'd0);
        check("rst_wait_wen",   32'(dwen),   32'd0);
        check("rst_wait_ldata", ldata,       32'd0);
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h5555_AAAA;
        @(negedge clk);
        rvalid = 1'b0;
        rst_n  = 1'b1;
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_8004, 32'h1122_3344, 0, 0, 32'h0, 1'b1,
               32'h0000_8004, 4'b1111, 32'h1122_3344, 32'h0, 1'b0);

        // Watchdog on the short instance: load that never gets a grant.
        @(negedge clk);
        c = cyc;
        valid4 = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_9000;
        exp4_q.push_back({1'b1, 1'b0, 32'h0});
        exp4_cyc_q.push_back(c + 5);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            valid4 = 1'b0;
            check("t_req_high", 32'(dreq4), 32'd1);
        end
        @(negedge clk);
        check("t_req_dropped", 32'(dreq4), 32'd0);
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("t_ready_after", 32'(ready4), 32'd1);
        check("t_ldata_after", ldata4, 32'd0);
        check("t_fault_held",  32'(fault4), 32'd1);

        repeat (5) @(negedge clk);
        check("pending_main", 32'(exp_q.size()), 32'd0);
        check("pending_short", 32'(exp4_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule
